uart_rx_fifo: RTL and testbench



---
 rtl/uart_rx_fifo_if.sv | 23 ++
 rtl/uart_rx_fifo.sv | 142 ++++++++++++++
 tb/tb_uart_rx_fifo.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// Consumer-facing bundle of the debug-link receiver: serial pin in, FIFO pop
// interface and error pulses out.
interface uart_rx_fifo_if #(
  parameter int DBIT = 8
);
  logic            i_rx;
  logic            i_rd;
  logic [DBIT-1:0] o_r_data;
  logic            o_rx_empty;
  logic            o_rx_full;
  logic            o_frame_err;
  logic            o_overrun;

  modport master (
    output i_rx, i_rd,
    input  o_r_data, o_rx_empty, o_rx_full, o_frame_err, o_overrun
  );

  modport slave (
    input  i_rx, i_rd,
    output o_r_data, o_rx_empty, o_rx_full, o_frame_err, o_overrun
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling feeding a first-word-fall-through
// FIFO consumed through an empty/pop interface.
module uart_rx_fifo #(
  parameter int DBIT     = 8,
  parameter int SB_TICK  = 16,
  parameter int DVSR     = 326,
  parameter int DVSR_BIT = 9,
  parameter int FIFO_W   = 5
) (
  input  logic          i_clk,
  input  logic          i_reset,
  uart_rx_fifo_if.slave bus
);
  localparam int NW    = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam int DEPTH = 1 << FIFO_W;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // two-flop synchronizer; idles high so reset never looks like a start bit
  logic rx_meta, rx_s;
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.i_rx;
      rx_s    <= rx_meta;
    end
  end

  logic [DVSR_BIT-1:0] tick_cnt;
  logic                tick;
  assign tick = (tick_cnt == DVSR_BIT'(DVSR - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset)   tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  state_t          state_q, state_d;
  logic [3:0]      s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] sh_q, sh_d;
  logic            push, ferr;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      sh_q    <= sh_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    sh_d    = sh_q;
    push    = 1'b0;
    ferr    = 1'b0;
    case (state_q)
      IDLE: if (!rx_s) begin
        state_d = START;
        s_d     = '0;
      end
      START: if (tick) begin
        if (s_q == 4'd7) begin
          // mid start bit: a high line here is a glitch, not a frame
          state_d = rx_s ? IDLE : DATA;
          s_d     = '0;
          n_d     = '0;
        end else s_d = s_q + 1'b1;
      end
      DATA: if (tick) begin
        if (s_q == 4'd15) begin
          s_d  = '0;
          sh_d = {rx_s, sh_q[DBIT-1:1]};
          if (n_q == NW'(DBIT - 1)) state_d = STOP;
          else                      n_d = n_q + 1'b1;
        end else s_d = s_q + 1'b1;
      end
      STOP: if (tick) begin
        if (s_q == 4'(SB_TICK - 1)) begin
          state_d = IDLE;
          push    = rx_s;
          ferr    = !rx_s;
        end else s_d = s_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  logic [DBIT-1:0]   mem [DEPTH];
  logic [FIFO_W-1:0] wr_ptr, rd_ptr;
  logic [FIFO_W:0]   count;
  logic              empty, full, do_pop, do_push, ovr;
  logic              frame_err_q, overrun_q;

  assign empty   = (count == '0);
  assign full    = (count == (FIFO_W+1)'(DEPTH));
  assign do_pop  = bus.i_rd && !empty;
  // a pop in the same cycle frees the slot, so full only drops when nobody reads
  assign do_push = push && (!full || do_pop);
  assign ovr     = push && full && !do_pop;

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= sh_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      frame_err_q <= ferr;
      overrun_q   <= ovr;
    end
  end

  assign bus.o_r_data    = empty ? '0 : mem[rd_ptr];
  assign bus.o_rx_empty  = empty;
  assign bus.o_rx_full   = full;
  assign bus.o_frame_err = frame_err_q;
  assign bus.o_overrun   = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: serial frames in, scoreboard of expected
// bytes checked against the FIFO head as it is popped.
module tb_uart_rx_fifo;
  localparam int DVSR    = 4;
  localparam int BIT_CYC = 16 * DVSR;

  logic i_clk = 1'b0;
  logic i_reset;
  always #5 i_clk = ~i_clk;

  uart_rx_fifo_if #(.DBIT(8)) bus ();

  uart_rx_fifo #(
    .DBIT(8), .SB_TICK(16), .DVSR(DVSR), .DVSR_BIT(3), .FIFO_W(5)
  ) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [7:0] exp_q[$];

  logic       pop_on_push = 1'b0;
  logic       pp_seen     = 1'b0;
  logic [7:0] pp_data     = '0;

  always @(posedge i_clk) begin
    fe_cnt <= fe_cnt + int'(bus.o_frame_err);
    ov_cnt <= ov_cnt + int'(bus.o_overrun);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  // bad stop: low through the sample point, released early so the tail is
  // not mistaken for a new start bit
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    logic bv;
    for (int i = 0; i < 10; i++) begin
      bv = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
      for (int c = 0; c < BIT_CYC; c++) begin
        if (i == 9 && !stop_ok) bus.i_rx = (c < 12 * DVSR) ? 1'b0 : 1'b1;
        else                    bus.i_rx = bv;
        bus.i_rd = 1'b0;
        if (pop_on_push && dut.push) begin
          bus.i_rd = 1'b1;
          pp_seen  = 1'b1;
          pp_data  = bus.o_r_data;
        end
        @(negedge i_clk);
      end
    end
    bus.i_rd = 1'b0;
    bus.i_rx = 1'b1;
    idle_cycles(4 * DVSR);
  endtask

  task automatic wait_data(input string tag);
    int k = 0;
    while (bus.o_rx_empty && k < 2000) begin
      @(negedge i_clk);
      k++;
    end
    check({tag, "_avail"}, 32'(bus.o_rx_empty), 32'd0);
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    wait_data(tag);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_data"}, 32'(bus.o_r_data), 32'(e));
    end
    bus.i_rd = 1'b1;
    @(negedge i_clk);
    bus.i_rd = 1'b0;
  endtask

  initial begin
    int fe0, ov0;
    bus.i_rx = 1'b1;
    bus.i_rd = 1'b0;
    i_reset  = 1'b1;
    idle_cycles(3);
    check("rst_empty", 32'(bus.o_rx_empty), 32'd1);
    check("rst_full",  32'(bus.o_rx_full),  32'd0);
    check("rst_data",  32'(bus.o_r_data),   32'd0);
    check("rst_ferr",  32'(bus.o_frame_err), 32'd0);
    check("rst_ovr",   32'(bus.o_overrun),  32'd0);
    i_reset = 1'b0;
    idle_cycles(BIT_CYC);

    // single frame
    send_frame(8'h04, 1'b1); exp_q.push_back(8'h04);
    pop_check("t1");
    check("t1_empty_after", 32'(bus.o_rx_empty), 32'd1);
    check("t1_data_after",  32'(bus.o_r_data),   32'd0);

    // glitch rejection then a clean frame
    bus.i_rx = 1'b0; idle_cycles(5 * DVSR);
    bus.i_rx = 1'b1; idle_cycles(40 * DVSR);
    check("t2_glitch_empty", 32'(bus.o_rx_empty), 32'd1);
    send_frame(8'h3F, 1'b1); exp_q.push_back(8'h3F);
    pop_check("t2");

    // framing error
    fe0 = fe_cnt;
    send_frame(8'hA5, 1'b0);
    idle_cycles(20 * DVSR);
    check("t3_ferr_pulses", 32'(fe_cnt - fe0), 32'd1);
    check("t3_empty", 32'(bus.o_rx_empty), 32'd1);

    // fill to full, then overrun on the 33rd
    ov0 = ov_cnt;
    for (int i = 0; i < 32; i++) begin
      send_frame(8'(i), 1'b1);
      exp_q.push_back(8'(i));
    end
    check("t4_full", 32'(bus.o_rx_full), 32'd1);
    check("t4_no_ovr_yet", 32'(ov_cnt - ov0), 32'd0);
    send_frame(8'h20, 1'b1);
    check("t4_ovr_pulse", 32'(ov_cnt - ov0), 32'd1);
    check("t4_still_full", 32'(bus.o_rx_full), 32'd1);

    // push and pop together while full
    ov0 = ov_cnt;
    pop_on_push = 1'b1;
    send_frame(8'h21, 1'b1);
    pop_on_push = 1'b0;
    check("t5_pp_seen", 32'(pp_seen), 32'd1);
    check("t5_pp_data", 32'(pp_data), 32'(exp_q.pop_front()));
    exp_q.push_back(8'h21);
    check("t5_pp_no_ovr", 32'(ov_cnt - ov0), 32'd0);
    check("t5_pp_full", 32'(bus.o_rx_full), 32'd1);
    for (int i = 0; i < 32; i++) pop_check("t4_drain");
    check("t4_drained_empty", 32'(bus.o_rx_empty), 32'd1);
    check("t4_drained_full",  32'(bus.o_rx_full),  32'd0);

    // stray pop while empty, then a stream
    bus.i_rd = 1'b1; @(negedge i_clk); bus.i_rd = 1'b0;
    check("t5_stray_empty", 32'(bus.o_rx_empty), 32'd1);
    check("t5_stray_data",  32'(bus.o_r_data),   32'd0);
    send_frame(8'h04, 1'b1); exp_q.push_back(8'h04); pop_check("t5_s0");
    send_frame(8'h00, 1'b1); exp_q.push_back(8'h00); pop_check("t5_s1");
    send_frame(8'h00, 1'b1); exp_q.push_back(8'h00); pop_check("t5_s2");
    send_frame(8'h3F, 1'b1); exp_q.push_back(8'h3F); pop_check("t5_s3");
    check("t5_end_empty", 32'(bus.o_rx_empty), 32'd1);

    // reset mid-frame with a byte already buffered
    send_frame(8'h3F, 1'b1);
    wait_data("t6_pre");
    fe0 = fe_cnt; ov0 = ov_cnt;
    bus.i_rx = 1'b0; idle_cycles(BIT_CYC);
    bus.i_rx = 1'b1; idle_cycles(3 * BIT_CYC + 8 * DVSR);
    i_reset = 1'b1; idle_cycles(2);
    check("t6_rst_empty", 32'(bus.o_rx_empty), 32'd1);
    check("t6_rst_full",  32'(bus.o_rx_full),  32'd0);
    check("t6_rst_data",  32'(bus.o_r_data),   32'd0);
    check("t6_rst_ferr",  32'(bus.o_frame_err), 32'd0);
    check("t6_rst_ovr",   32'(bus.o_overrun),  32'd0);
    i_reset = 1'b0;
    exp_q.delete();
    idle_cycles(8 * BIT_CYC);
    check("t6_no_byte", 32'(bus.o_rx_empty), 32'd1);
    check("t6_no_pulses", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'd0);
    send_frame(8'h05, 1'b1); exp_q.push_back(8'h05);
    pop_check("t6_after");
    check("t6_final_empty", 32'(bus.o_rx_empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
